main_memory_responder: RTL and testbench

MAIN_MEMORY_RESPONDER -- requirements
Module: main_memory_responder

---
 rtl/main_memory_responder.sv | 144 ++++++++++++++
 tb/tb_main_memory_responder.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/main_memory_responder.sv
// Word-addressed main-memory model that answers cache-controller requests:
// 4-word block reads and single-word write-throughs, each after a fixed latency.
module main_memory_responder #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned LATENCY     = 4,
    parameter int unsigned BLOCK_WORDS = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              req_ready,
    output logic              rd_valid,
    output logic [1:0]        rd_idx,
    output logic [31:0]       rd_data,
    output logic              rd_last,
    output logic              wr_done
);

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned CNT_W     = 4;
    localparam int unsigned IDX_W     = $clog2(BLOCK_WORDS);
    localparam int unsigned MEM_DEPTH = 2 ** ADDR_W;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(BLOCK_WORDS - 1);
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2,
        WDONE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [ADDR_W-1:0]   addr_q;
    logic                write_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                accept_c;
    logic                mem_we_c;
    logic [ADDR_W-1:0]   rd_addr_c;

    logic [DATA_W-1:0]   mem [MEM_DEPTH];

    // State, latency counter and burst index.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    // Request capture at acceptance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
        end else if (accept_c) begin
            addr_q  <= req_addr;
            write_q <= req_write;
            wdata_q <= req_wdata;
        end
    end

    // Next-state logic; memory write fires on the WAIT -> WDONE edge.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        accept_c = 1'b0;
        mem_we_c = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    accept_c = 1'b1;
                    cnt_d    = WAIT_LOAD;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    idx_d    = '0;
                    mem_we_c = write_q;
                    state_d  = write_q ? WDONE : BURST;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            BURST: begin
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            WDONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Block base keeps the upper address bits; the offset comes from the burst index.
    assign rd_addr_c = {addr_q[ADDR_W-1:IDX_W], idx_d};

    // Storage is never reset, so a reset cannot disturb its contents.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem[addr_q] <= wdata_q;
        end
    end

    // Registered outputs, computed from the upcoming state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_ready <= 1'b1;
            rd_valid  <= 1'b0;
            rd_idx    <= '0;
            rd_data   <= '0;
            rd_last   <= 1'b0;
            wr_done   <= 1'b0;
        end else begin
            req_ready <= (state_d == IDLE);
            rd_valid  <= (state_d == BURST);
            rd_idx    <= (state_d == BURST) ? 2'(idx_d) : 2'd0;
            rd_data   <= (state_d == BURST) ? mem[rd_addr_c] : '0;
            rd_last   <= (state_d == BURST) && (idx_d == LAST_IDX);
            wr_done   <= (state_d == WDONE);
        end
    end

endmodule

// File: tb/tb_main_memory_responder.sv
// Directed plus randomized checks of main_memory_responder against a sparse
// word-array model with cycle-exact timing expectations.
module tb_main_memory_responder;

    localparam int unsigned AW  = 10;
    localparam int unsigned LAT = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          req_ready;
    logic          rd_valid;
    logic [1:0]    rd_idx;
    logic [31:0]   rd_data;
    logic          rd_last;
    logic          wr_done;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] model_mem [int];

    main_memory_responder #(.ADDR_W(AW), .LATENCY(LAT), .BLOCK_WORDS(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rd_valid  (rd_valid),
        .rd_idx    (rd_idx),
        .rd_data   (rd_data),
        .rd_last   (rd_last),
        .wr_done   (wr_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".ready"},   32'(req_ready), 32'd1);
        check({tag, ".rdvalid"}, 32'(rd_valid),  32'd0);
        check({tag, ".rdidx"},   32'(rd_idx),    32'd0);
        check({tag, ".rddata"},  rd_data,        32'd0);
        check({tag, ".rdlast"},  32'(rd_last),   32'd0);
        check({tag, ".wrdone"},  32'(wr_done),   32'd0);
    endtask

    // Called at a negedge; returns at the negedge of the first cycle ready is back.
    task automatic do_write(input logic [AW-1:0] addr, input logic [31:0] data);
        req_valid = 1'b1; req_write = 1'b1; req_addr = addr; req_wdata = data;
        check("wr.ready_pre", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int k = 0; k <= int'(LAT); k++) begin
            @(negedge clk);
            check($sformatf("wr.busy_ready[%0d]", k), 32'(req_ready), 32'd0);
            check($sformatf("wr.done[%0d]", k), 32'(wr_done), 32'(k == int'(LAT)));
            check($sformatf("wr.rdvalid[%0d]", k), 32'(rd_valid), 32'd0);
        end
        model_mem[int'(addr)] = data;
        @(negedge clk);
        check("wr.ready_post", 32'(req_ready), 32'd1);
        check("wr.done_post",  32'(wr_done),   32'd0);
    endtask

    // keep=1 leaves req_valid high with a new address for the whole transaction.
    task automatic do_read(input logic [AW-1:0] addr, input bit keep, input logic [AW-1:0] nxt);
        int base;
        req_valid = 1'b1; req_write = 1'b0; req_addr = addr; req_wdata = $urandom;
        check("rd.ready_pre", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        if (keep) req_addr = nxt;
        else      req_valid = 1'b0;
        base = int'(addr) & ~3;
        for (int k = 0; k < int'(LAT) + 4; k++) begin
            @(negedge clk);
            check($sformatf("rd.busy_ready[%0d]", k), 32'(req_ready), 32'd0);
            if (k < int'(LAT)) begin
                check($sformatf("rd.wait_valid[%0d]", k), 32'(rd_valid), 32'd0);
                check($sformatf("rd.wait_data[%0d]", k),  rd_data,       32'd0);
            end else begin
                int w = k - int'(LAT);
                check($sformatf("rd.valid[%0d]", w), 32'(rd_valid), 32'd1);
                check($sformatf("rd.idx[%0d]", w),   32'(rd_idx),   32'(w));
                check($sformatf("rd.last[%0d]", w),  32'(rd_last),  32'(w == 3));
                if (model_mem.exists(base + w))
                    check($sformatf("rd.data@%0d", base + w), rd_data, model_mem[base + w]);
            end
        end
        @(negedge clk);
        check("rd.ready_post", 32'(req_ready), 32'd1);
        check("rd.valid_post", 32'(rd_valid),  32'd0);
        check("rd.idx_post",   32'(rd_idx),    32'd0);
        check("rd.data_post",  rd_data,        32'd0);
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        #1;
        check_idle_outputs("reset.async");
        repeat (3) @(negedge clk);
        check_idle_outputs("reset.held");
        reset = 1'b0;
        @(negedge clk);

        // Block of four writes then reads at various offsets.
        do_write(10'd128, 32'h1);
        do_write(10'd129, 32'h2);
        do_write(10'd130, 32'h3);
        do_write(10'd131, 32'h4);
        do_read(10'd130, 1'b0, '0);
        do_write(10'd130, 32'hF);
        do_read(10'd128, 1'b0, '0);

        // Request held through a burst is accepted once, right after rd_last.
        do_read(10'd129, 1'b1, 10'd131);
        do_read(10'd131, 1'b0, '0);
        @(negedge clk);
        check("hold.no_reaccept", 32'(req_ready), 32'd1);

        // Reset during WAIT of a write: memory untouched, outputs at reset values.
        req_valid = 1'b1; req_write = 1'b1; req_addr = 10'd129; req_wdata = 32'hAA;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("abortw.busy", 32'(req_ready), 32'd0);
        reset = 1'b1; #1;
        check_idle_outputs("abortw.reset");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < int'(LAT) + 2; k++) begin
            @(negedge clk);
            check($sformatf("abortw.nodone[%0d]", k), 32'(wr_done), 32'd0);
        end
        do_read(10'd128, 1'b0, '0);

        // Reset mid-burst: no remaining words appear.
        req_valid = 1'b1; req_write = 1'b0; req_addr = 10'd128;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (int'(LAT) + 1) @(negedge clk);
        check("abortr.inburst", 32'(rd_valid), 32'd1);
        reset = 1'b1; #1;
        check_idle_outputs("abortr.reset");
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check($sformatf("abortr.quiet[%0d]", k), 32'(rd_valid), 32'd0);
        end

        // Top-of-memory block.
        do_write(10'd1023, 32'h77);
        do_read(10'd1020, 1'b0, '0);

        // Randomized mix against the sparse model.
        for (int i = 0; i < 40; i++) begin
            logic [AW-1:0] a;
            a = ($urandom_range(0, 3) == 0) ? AW'(10'd1020 + AW'($urandom_range(0, 3)))
                                            : AW'($urandom_range(120, 140));
            if ($urandom_range(0, 1) == 1) do_write(a, $urandom);
            else                           do_read(a, 1'b0, '0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
